// File: rtl/gshare_global_predictor_pkg.sv
// Shared definitions for the gshare predictor and the branch chooser:
// counter encodings, FSM states, direction constants and default table sizes.
package gshare_global_predictor_pkg;

  localparam int PHT_AW_DEF = 8;
  localparam int GHR_W_DEF  = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic DIR_TAKEN     = 1'b1;
  localparam logic DIR_NOT_TAKEN = 1'b0;

  // The MSB of a 2-bit counter is the predicted direction.
  function automatic logic ctr_taken(input logic [1:0] cnt);
    return cnt[1];
  endfunction

endpackage

// File: rtl/gshare_global_predictor_if.sv
// Fetch-lookup and execute-update bundle between the pipeline (master)
// and the gshare predictor (slave).
interface gshare_global_predictor_if
  import gshare_global_predictor_pkg::*;
#(
  parameter int PHT_AW = PHT_AW_DEF
);

  logic              stall;
  logic              ready;
  logic              fetch_valid;
  logic [31:0]       fetch_pc;
  logic              predict_taken;
  logic [PHT_AW-1:0] pred_index;
  logic              upd_valid;
  logic [PHT_AW-1:0] upd_index;
  logic              upd_taken;
  logic              upd_mispredict;

  modport master (
    output stall, fetch_valid, fetch_pc,
    output upd_valid, upd_index, upd_taken, upd_mispredict,
    input  ready, predict_taken, pred_index
  );

  modport slave (
    input  stall, fetch_valid, fetch_pc,
    input  upd_valid, upd_index, upd_taken, upd_mispredict,
    output ready, predict_taken, pred_index
  );

endinterface

// File: rtl/gshare_global_predictor_sat_counter2.sv
// Combinational next-state of a 2-bit saturating direction counter;
// shared by the gshare table and the chooser.
module bp_sat_counter2
  import gshare_global_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken == DIR_TAKEN) begin
      if (cnt != ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_global_predictor.sv
// gshare direction predictor: PC xor speculative global history indexes a
// table of 2-bit counters trained at execute; mispredicts restore history.
module gshare_global_predictor
  import gshare_global_predictor_pkg::*;
#(
  parameter int PHT_AW = PHT_AW_DEF,
  parameter int GHR_W  = GHR_W_DEF
)(
  input  logic                       clk,
  input  logic                       resetn,
  gshare_global_predictor_if.slave   bus
);

  localparam int DEPTH = 1 << PHT_AW;

  if (GHR_W > PHT_AW) begin : g_bad_ghr_w
    $error("GHR_W must not exceed PHT_AW");
  end

  state_e            state;
  logic [PHT_AW-1:0] init_ptr;
  logic [GHR_W-1:0]  spec_ghr;
  logic [GHR_W-1:0]  arch_ghr;
  logic [1:0]        pht [DEPTH];

  logic              run;
  logic              flush;
  logic [PHT_AW-1:0] idx;
  logic [1:0]        upd_cnt;
  logic [1:0]        upd_cnt_next;
  logic              pht_we;
  logic [PHT_AW-1:0] pht_wa;
  logic [1:0]        pht_wd;
  logic              unused_pc_bits;

  function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] ghr,
                                                 input logic            dir);
    return GHR_W'({ghr, dir});
  endfunction

  assign run   = (state == RUN);
  assign flush = bus.upd_valid & bus.upd_mispredict;

  // Lookup: history is zero-extended on the left before the XOR.
  assign idx               = bus.fetch_pc[PHT_AW+1:2] ^ PHT_AW'(spec_ghr);
  assign bus.pred_index    = run ? idx : '0;
  assign bus.predict_taken = run & bus.fetch_valid & ctr_taken(pht[idx]);
  assign bus.ready         = run;

  assign unused_pc_bits = ^{bus.fetch_pc[31:PHT_AW+2], bus.fetch_pc[1:0]};

  assign upd_cnt = pht[bus.upd_index];

  bp_sat_counter2 u_upd_ctr (
    .cnt      (upd_cnt),
    .taken    (bus.upd_taken),
    .cnt_next (upd_cnt_next)
  );

  // Single table write port: the init sweep while in INIT, training in RUN.
  always_comb begin
    pht_we = 1'b0;
    pht_wa = init_ptr;
    pht_wd = WNT;
    if (resetn) begin
      if (!run) begin
        pht_we = 1'b1;
      end else if (!bus.stall && bus.upd_valid) begin
        pht_we = 1'b1;
        pht_wa = bus.upd_index;
        pht_wd = upd_cnt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= INIT;
      init_ptr <= '0;
      spec_ghr <= '0;
      arch_ghr <= '0;
    end else if (!run) begin
      init_ptr <= init_ptr + PHT_AW'(1);
      if (&init_ptr) state <= RUN;
    end else if (!bus.stall) begin
      // A flush overrides the shift of any lookup made in the same cycle.
      if (flush)
        spec_ghr <= ghr_shift(arch_ghr, bus.upd_taken);
      else if (bus.fetch_valid)
        spec_ghr <= ghr_shift(spec_ghr, bus.predict_taken);
      if (bus.upd_valid)
        arch_ghr <= ghr_shift(arch_ghr, bus.upd_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (pht_we) pht[pht_wa] <= pht_wd;
  end

endmodule

// File: tb/tb_gshare_global_predictor.sv
// Bench for gshare_global_predictor: directed vector table plus random traffic
// against an array-based reference model.
module tb_gshare_global_predictor;

  localparam int AW = 8;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  gshare_global_predictor_if #(.PHT_AW(AW)) bus();

  gshare_global_predictor #(.PHT_AW(AW), .GHR_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  int m_pht [N];
  int m_spec;
  int m_arch;

  typedef struct {
    bit          rst;
    bit          fv;
    logic [31:0] pc;
    bit          uv;
    int          ui;
    bit          ut;
    bit          um;
    bit          st;
    int          pt;
    int          idx;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit fv, input logic [31:0] pc, input bit uv, input int ui,
                       input bit ut, input bit um, input bit st);
    bus.fetch_valid    = fv;
    bus.fetch_pc       = pc;
    bus.upd_valid      = uv;
    bus.upd_index      = ui[AW-1:0];
    bus.upd_taken      = ut;
    bus.upd_mispredict = um;
    bus.stall          = st;
  endtask

  function automatic int model_idx(input logic [31:0] pc);
    return ((int'(pc) >> 2) & (N - 1)) ^ m_spec;
  endfunction

  function automatic int model_pt(input bit fv, input logic [31:0] pc);
    return (fv && m_pht[model_idx(pc)] >= 2) ? 1 : 0;
  endfunction

  task automatic model_step(input bit fv, input logic [31:0] pc, input bit uv, input int ui,
                            input bit ut, input bit um, input bit st);
    int p;
    p = model_pt(fv, pc);
    if (!st) begin
      if (uv && um)  m_spec = ((m_arch << 1) | int'(ut)) & 255;
      else if (fv)   m_spec = ((m_spec << 1) | p) & 255;
      if (uv) begin
        m_arch = ((m_arch << 1) | int'(ut)) & 255;
        if (ut) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
        else    m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
      end
    end
  endtask

  task automatic reset_and_init();
    int k;
    int bad;
    drive(1'b1, 32'h48, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", bus.ready, 0);
    check("rst_pt", bus.predict_taken, 0);
    check("rst_idx", bus.pred_index, 0);
    resetn = 1'b1;
    k = 0;
    bad = 0;
    while (k < 400) begin
      drive(1'b1, $urandom, 1'b1, $urandom_range(0, N - 1), 1'($urandom), 1'($urandom),
            1'($urandom));
      #1;
      if (bus.ready) begin
        drive(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        break;
      end
      if (bus.predict_taken !== 1'b0 || bus.pred_index !== '0) bad++;
      @(negedge clk);
      k++;
    end
    check("init_cycles", k, N);
    check("init_outputs_zero", bad, 0);
    for (int i = 0; i < N; i++) m_pht[i] = 1;
    m_spec = 0;
    m_arch = 0;
  endtask

  task automatic run_cycle(input bit fv, input logic [31:0] pc, input bit uv, input int ui,
                           input bit ut, input bit um, input bit st, input bit use_tbl,
                           input int e_pt, input int e_idx, input string tag);
    int ept;
    int eidx;
    @(negedge clk);
    drive(fv, pc, uv, ui, ut, um, st);
    #1;
    ept  = use_tbl ? e_pt  : model_pt(fv, pc);
    eidx = use_tbl ? e_idx : model_idx(pc);
    check({tag, "_pt"}, bus.predict_taken, ept);
    check({tag, "_idx"}, bus.pred_index, eidx);
    model_step(fv, pc, uv, ui, ut, um, st);
  endtask

  task automatic add(input bit rst, input bit fv, input logic [31:0] pc, input bit uv,
                     input int ui, input bit ut, input bit um, input bit st,
                     input int pt, input int idx);
    vec_t v;
    v.rst = rst; v.fv = fv; v.pc = pc; v.uv = uv; v.ui = ui;
    v.ut = ut; v.um = um; v.st = st; v.pt = pt; v.idx = idx;
    tbl.push_back(v);
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    //  rst fv pc         uv ui     ut um st  pt idx
    // training of entry 0x12 and saturation both ways
    add(1, 0, 32'h0,      1, 'h12,  1, 0, 0,  0, 'h00);
    add(0, 0, 32'h0,      1, 'h12,  1, 0, 0,  0, 'h00);
    add(0, 1, 32'h48,     0, 0,     0, 0, 0,  1, 'h12);
    add(0, 0, 32'h48,     1, 'h12,  1, 0, 0,  0, 'h13);
    add(0, 0, 32'h48,     1, 'h12,  1, 0, 0,  0, 'h13);
    add(0, 0, 32'h48,     1, 'h12,  1, 0, 0,  0, 'h13);
    add(0, 0, 32'h48,     1, 'h12,  0, 0, 0,  0, 'h13);
    add(0, 0, 32'h48,     1, 'h12,  0, 0, 0,  0, 'h13);
    add(0, 1, 32'h4C,     0, 0,     0, 0, 0,  0, 'h12);
    add(0, 0, 32'h0,      1, 'h12,  1, 0, 0,  0, 'h02);
    add(0, 0, 32'h0,      1, 'h12,  1, 0, 0,  0, 'h02);
    // reset mid-run: entry 0x12 (was ST) back to WNT, history cleared
    add(1, 1, 32'h48,     0, 0,     0, 0, 0,  0, 'h12);
    add(0, 0, 32'h0,      1, 'h12,  1, 0, 0,  0, 'h00);
    add(0, 1, 32'h48,     0, 0,     0, 0, 0,  1, 'h12);
    // speculative history T,T,NT -> 0x06
    add(1, 0, 32'h0,      1, 'h05,  1, 0, 0,  0, 'h00);
    add(0, 1, 32'h14,     0, 0,     0, 0, 0,  1, 'h05);
    add(0, 1, 32'h10,     0, 0,     0, 0, 0,  1, 'h05);
    add(0, 1, 32'h40,     0, 0,     0, 0, 0,  0, 'h13);
    add(0, 1, 32'h48,     0, 0,     0, 0, 0,  0, 'h14);
    // steer spec_ghr to 0xB6 with predictions 1,0,1,1,0,1,1,0
    add(0, 1, 32'h24,     0, 0,     0, 0, 0,  1, 'h05);
    add(0, 1, 32'h28,     0, 0,     0, 0, 0,  0, 'h13);
    add(0, 1, 32'hDC,     0, 0,     0, 0, 0,  1, 'h05);
    add(0, 1, 32'h180,    0, 0,     0, 0, 0,  1, 'h05);
    add(0, 1, 32'h360,    0, 0,     0, 0, 0,  0, 'h13);
    add(0, 1, 32'h24C,    0, 0,     0, 0, 0,  1, 'h05);
    add(0, 1, 32'hA0,     0, 0,     0, 0, 0,  1, 'h05);
    add(0, 1, 32'h120,    0, 0,     0, 0, 0,  0, 'h13);
    // recovery: arch=0x01, spec=0xB6, flush with same-cycle lookup
    add(0, 1, 32'h48,     1, 'h30,  0, 1, 0,  0, 'hA4);
    add(0, 0, 32'h0,      0, 0,     0, 0, 0,  0, 'h02);
    // same-index lookup/update: no bypass
    add(0, 1, 32'h88,     1, 'h20,  1, 0, 0,  0, 'h20);
    add(0, 1, 32'h90,     0, 0,     0, 0, 0,  1, 'h20);
    // stall for five cycles under a held update, then release
    add(0, 1, 32'hA4,     1, 'h20,  0, 0, 1,  1, 'h20);
    add(0, 1, 32'hA4,     1, 'h20,  0, 0, 1,  1, 'h20);
    add(0, 1, 32'hA4,     1, 'h20,  0, 0, 1,  1, 'h20);
    add(0, 1, 32'hA4,     1, 'h20,  0, 0, 1,  1, 'h20);
    add(0, 1, 32'hA4,     1, 'h20,  0, 0, 1,  1, 'h20);
    add(0, 1, 32'hA4,     1, 'h20,  0, 0, 0,  1, 'h20);
    add(0, 0, 32'h0,      1, 'h20,  1, 0, 0,  0, 'h13);
    add(0, 1, 32'hCC,     0, 0,     0, 0, 0,  1, 'h20);
    // arch_ghr advanced exactly once across the stall
    add(0, 0, 32'h0,      1, 'h31,  1, 1, 0,  0, 'h27);
    add(0, 0, 32'h0,      0, 0,     0, 0, 0,  0, 'h2B);

    foreach (tbl[i]) begin
      if (tbl[i].rst) reset_and_init();
      run_cycle(tbl[i].fv, tbl[i].pc, tbl[i].uv, tbl[i].ui, tbl[i].ut, tbl[i].um,
                tbl[i].st, 1'b1, tbl[i].pt, tbl[i].idx, $sformatf("vec%0d", i));
    end

    // random traffic against the reference model, small index range for collisions
    for (int n = 0; n < 3000; n++) begin
      run_cycle(1'($urandom), {22'h0, 8'($urandom_range(0, 31)), 2'($urandom)},
                1'($urandom), $urandom_range(0, 31), 1'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                1'b0, 0, 0, $sformatf("rnd%0d", n));
    end
    #1;
    check("run_ready", bus.ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
